// File: rtl/lock_controller.sv
// -----------------------------------------------------------------------------
// lock_controller
//
// Digital-lock sequencer. It collects BCD keypad digits and compares a complete
// entry against the stored code. On a match it opens the lock. While the lock
// is open the code can be reprogrammed. It requests error or success blink
// sequences from the downstream LED blinker through a two-phase handshake.
//
// Ports
//   hwclk          in   1   system clock (12 MHz)
//   rst_n          in   1   asynchronous active-low reset (deassertion is synchronised here)
//   key_valid      in   1   1-cycle pulse, key_digit valid this cycle
//   key_digit      in   4   BCD digit 0..9; 10..15 ignored
//   prog_req       in   1   1-cycle pulse, enter programming mode (UNLOCKED only)
//   lock_req       in   1   1-cycle pulse, relock (UNLOCKED or PROG)
//   done_blinking  in   1   blinker status: 0 while running, 1 when idle/complete
//   start_blinking out  1   rising edge starts a blink sequence
//   blink_type     out  1   0 = error sequence, 1 = success sequence
//   unlocked       out  1   1 while the lock is open
//   busy           out  1   1 in any BLINK_* state; keys are ignored while busy
// -----------------------------------------------------------------------------
module lock_controller #(
    parameter int                    CODE_LEN      = 4,
    parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE  = 16'h1234,
    parameter logic [31:0]           ENTRY_TIMEOUT = 32'd60000000
) (
    input  logic       hwclk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       prog_req,
    input  logic       lock_req,
    input  logic       done_blinking,
    output logic       start_blinking,
    output logic       blink_type,
    output logic       unlocked,
    output logic       busy
);

    localparam int         CODE_W    = 4 * CODE_LEN;
    localparam logic [3:0] CODE_LEN_C = 4'(CODE_LEN);

    typedef enum logic [2:0] {
        ST_LOCKED      = 3'd0,
        ST_PROG        = 3'd1,
        ST_BLINK_SETUP = 3'd2,
        ST_BLINK_ACK   = 3'd3,
        ST_BLINK_WAIT  = 3'd4,
        ST_UNLOCKED    = 3'd5
    } state_t;

    // Shift one new digit into the least significant nibble of an entry.
    function automatic logic [CODE_W-1:0] shift_digit(input logic [CODE_W-1:0] entry,
                                                      input logic [3:0]        digit);
        logic [CODE_W-1:0] shifted;
        shifted      = entry << 4;
        shifted[3:0] = digit;
        return shifted;
    endfunction

    logic [1:0]        rst_sync_r;
    logic              rst_int_n_s;

    state_t            state_r;
    state_t            ret_state_r;
    logic [CODE_W-1:0] code_r;
    logic [CODE_W-1:0] entry_r;
    logic [3:0]        digit_cnt_r;
    logic [31:0]       timer_r;

    logic              key_ok_s;
    logic              entry_full_s;
    logic              timeout_s;
    logic [CODE_W-1:0] entry_next_s;

    // Reset synchroniser: assertion is immediate, release is aligned to hwclk.
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_int_n_s = rst_sync_r[1];

    // Entry qualifiers shared by the LOCKED and PROG states.
    always_comb begin
        key_ok_s     = 1'b0;
        entry_full_s = 1'b0;
        timeout_s    = 1'b0;
        entry_next_s = shift_digit(entry_r, key_digit);
        if (key_valid && (key_digit <= 4'd9)) begin
            key_ok_s = 1'b1;
        end else begin
            key_ok_s = 1'b0;
        end
        if (digit_cnt_r == CODE_LEN_C) begin
            entry_full_s = 1'b1;
        end else begin
            entry_full_s = 1'b0;
        end
        if ((digit_cnt_r != 4'd0) && (timer_r == (ENTRY_TIMEOUT - 32'd1))) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Main lock FSM with registered handshake and status outputs.
    always_ff @(posedge hwclk or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            state_r        <= ST_LOCKED;
            ret_state_r    <= ST_LOCKED;
            code_r         <= DEFAULT_CODE;
            entry_r        <= '0;
            digit_cnt_r    <= 4'd0;
            timer_r        <= 32'd0;
            start_blinking <= 1'b0;
            blink_type     <= 1'b0;
            unlocked       <= 1'b0;
            busy           <= 1'b0;
        end else begin
            case (state_r)
                ST_LOCKED: begin
                    if (entry_full_s) begin
                        // Complete entry: decide; any key arriving now is dropped.
                        entry_r     <= '0;
                        digit_cnt_r <= 4'd0;
                        timer_r     <= 32'd0;
                        if (entry_r == code_r) begin
                            state_r  <= ST_UNLOCKED;
                            unlocked <= 1'b1;
                        end else begin
                            blink_type  <= 1'b0;
                            ret_state_r <= ST_LOCKED;
                            state_r     <= ST_BLINK_SETUP;
                            busy        <= 1'b1;
                        end
                    end else if (key_ok_s) begin
                        entry_r     <= entry_next_s;
                        digit_cnt_r <= digit_cnt_r + 4'd1;
                        timer_r     <= 32'd0;
                    end else if (timeout_s) begin
                        // Abandoned partial entry is discarded silently.
                        entry_r     <= '0;
                        digit_cnt_r <= 4'd0;
                        timer_r     <= 32'd0;
                    end else if (digit_cnt_r != 4'd0) begin
                        timer_r <= timer_r + 32'd1;
                    end else begin
                        timer_r <= 32'd0;
                    end
                end

                ST_PROG: begin
                    if (lock_req) begin
                        // Abort programming; the stored code is left untouched.
                        state_r     <= ST_LOCKED;
                        unlocked    <= 1'b0;
                        entry_r     <= '0;
                        digit_cnt_r <= 4'd0;
                        timer_r     <= 32'd0;
                    end else if (entry_full_s) begin
                        code_r      <= entry_r;
                        unlocked    <= 1'b0;
                        blink_type  <= 1'b1;
                        ret_state_r <= ST_LOCKED;
                        state_r     <= ST_BLINK_SETUP;
                        busy        <= 1'b1;
                        entry_r     <= '0;
                        digit_cnt_r <= 4'd0;
                        timer_r     <= 32'd0;
                    end else if (key_ok_s) begin
                        entry_r     <= entry_next_s;
                        digit_cnt_r <= digit_cnt_r + 4'd1;
                        timer_r     <= 32'd0;
                    end else if (timeout_s) begin
                        entry_r     <= '0;
                        digit_cnt_r <= 4'd0;
                        timer_r     <= 32'd0;
                    end else if (digit_cnt_r != 4'd0) begin
                        timer_r <= timer_r + 32'd1;
                    end else begin
                        timer_r <= 32'd0;
                    end
                end

                ST_UNLOCKED: begin
                    entry_r     <= '0;
                    digit_cnt_r <= 4'd0;
                    timer_r     <= 32'd0;
                    // lock_req has priority over prog_req.
                    if (lock_req) begin
                        state_r  <= ST_LOCKED;
                        unlocked <= 1'b0;
                    end else if (prog_req) begin
                        state_r <= ST_PROG;
                    end else begin
                        state_r <= ST_UNLOCKED;
                    end
                end

                ST_BLINK_SETUP: begin
                    // blink_type was set one cycle earlier, so it leads this rise.
                    start_blinking <= 1'b1;
                    state_r        <= ST_BLINK_ACK;
                end

                ST_BLINK_ACK: begin
                    if (!done_blinking) begin
                        state_r <= ST_BLINK_WAIT;
                    end else begin
                        state_r <= ST_BLINK_ACK;
                    end
                end

                ST_BLINK_WAIT: begin
                    // No timeout here: a stuck blinker holds us until reset.
                    if (done_blinking) begin
                        start_blinking <= 1'b0;
                        busy           <= 1'b0;
                        state_r        <= ret_state_r;
                    end else begin
                        state_r <= ST_BLINK_WAIT;
                    end
                end

                default: begin
                    state_r        <= ST_LOCKED;
                    start_blinking <= 1'b0;
                    unlocked       <= 1'b0;
                    busy           <= 1'b0;
                    entry_r        <= '0;
                    digit_cnt_r    <= 4'd0;
                    timer_r        <= 32'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lock_controller.sv
module tb_lock_controller;

    logic       hwclk;
    logic       rst_n;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       prog_req;
    logic       lock_req;
    logic       done_blinking;
    logic       start_blinking;
    logic       blink_type;
    logic       unlocked;
    logic       busy;

    int checks;
    int failures;

    lock_controller #(
        .CODE_LEN      (4),
        .DEFAULT_CODE  (16'h1234),
        .ENTRY_TIMEOUT (32'd100)
    ) dut (
        .hwclk          (hwclk),
        .rst_n          (rst_n),
        .key_valid      (key_valid),
        .key_digit      (key_digit),
        .prog_req       (prog_req),
        .lock_req       (lock_req),
        .done_blinking  (done_blinking),
        .start_blinking (start_blinking),
        .blink_type     (blink_type),
        .unlocked       (unlocked),
        .busy           (busy)
    );

    initial hwclk = 1'b0;
    always #5 hwclk = ~hwclk;

    // All tasks start and end 1 time unit after a rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge hwclk);
            #1;
        end
    endtask

    task automatic press(input logic [3:0] d);
        key_digit = d;
        key_valid = 1'b1;
        tick(1);
        key_valid = 1'b0;
        key_digit = 4'd0;
    endtask

    task automatic press_code(input logic [15:0] c);
        logic [15:0] v;
        v = c;
        for (int i = 3; i >= 0; i--) begin
            press(v[4*i +: 4]);
        end
    endtask

    task automatic pulse_lock();
        lock_req = 1'b1;
        tick(1);
        lock_req = 1'b0;
    endtask

    // Behaves as the blinker: waits for the request, runs for 'hold' cycles, completes.
    task automatic run_blinker(input int hold, output bit ok, output logic bt);
        int n;
        ok = 1'b0;
        bt = 1'bx;
        n  = 0;
        while (start_blinking !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        if (start_blinking === 1'b1) begin
            bt = blink_type;
            done_blinking = 1'b0;
            tick(hold);
            done_blinking = 1'b1;
            n = 0;
            while (start_blinking !== 1'b0 && n < 5) begin
                tick(1);
                n++;
            end
            ok = (start_blinking === 1'b0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(2);
        checks++;
        if ({start_blinking, blink_type, unlocked, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 0000", {start_blinking, blink_type, unlocked, busy});
        end
        rst_n = 1'b1;
        tick(4);
        checks++;
        if ({start_blinking, unlocked, busy} !== 3'b000) begin
            failures++;
            $display("FAIL reset_release: got %b expected 000", {start_blinking, unlocked, busy});
        end
    endtask

    task automatic test_unlock();
        press_code(16'h1234);
        checks++;
        if (unlocked !== 1'b0) begin
            failures++;
            $display("FAIL unlock_early: unlocked=%b expected 0", unlocked);
        end
        tick(1);
        checks++;
        if (unlocked !== 1'b1 || start_blinking !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL unlock_default: unlocked=%b start=%b busy=%b expected 1 0 0", unlocked, start_blinking, busy);
        end
        pulse_lock();
        checks++;
        if (unlocked !== 1'b0) begin
            failures++;
            $display("FAIL relock: unlocked=%b expected 0", unlocked);
        end
    endtask

    task automatic test_wrong_code();
        press_code(16'h1235);
        tick(1);
        checks++;
        if (busy !== 1'b1 || start_blinking !== 1'b0 || blink_type !== 1'b0) begin
            failures++;
            $display("FAIL err_setup: busy=%b start=%b type=%b expected 1 0 0", busy, start_blinking, blink_type);
        end
        tick(1);
        checks++;
        if (start_blinking !== 1'b1 || blink_type !== 1'b0) begin
            failures++;
            $display("FAIL err_start: start=%b type=%b expected 1 0", start_blinking, blink_type);
        end
        done_blinking = 1'b0;
        tick(10);
        checks++;
        if (start_blinking !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL err_hold: start=%b busy=%b expected 1 1", start_blinking, busy);
        end
        done_blinking = 1'b1;
        tick(1);
        checks++;
        if (start_blinking !== 1'b0 || busy !== 1'b0 || unlocked !== 1'b0) begin
            failures++;
            $display("FAIL err_done: start=%b busy=%b unlocked=%b expected 0 0 0", start_blinking, busy, unlocked);
        end
    endtask

    task automatic test_timeout();
        press(4'd1);
        press(4'd2);
        tick(100);
        press_code(16'h1234);
        tick(1);
        checks++;
        if (unlocked !== 1'b1 || start_blinking !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_discard: unlocked=%b start=%b busy=%b expected 1 0 0", unlocked, start_blinking, busy);
        end
        pulse_lock();
        // One cycle short of the timeout: the partial entry must survive.
        press(4'd1);
        press(4'd2);
        tick(98);
        press(4'd3);
        press(4'd4);
        tick(1);
        checks++;
        if (unlocked !== 1'b1) begin
            failures++;
            $display("FAIL timeout_boundary: unlocked=%b expected 1", unlocked);
        end
        pulse_lock();
    endtask

    task automatic test_invalid_and_priority();
        press(4'd12);
        press(4'd1);
        press(4'd15);
        press(4'd2);
        press(4'd3);
        press(4'd4);
        tick(1);
        checks++;
        if (unlocked !== 1'b1) begin
            failures++;
            $display("FAIL invalid_digits: unlocked=%b expected 1", unlocked);
        end
        lock_req = 1'b1;
        prog_req = 1'b1;
        tick(1);
        lock_req = 1'b0;
        prog_req = 1'b0;
        checks++;
        if (unlocked !== 1'b0) begin
            failures++;
            $display("FAIL lock_wins: unlocked=%b expected 0", unlocked);
        end
        tick(2);
        checks++;
        if (start_blinking !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL lock_no_blink: start=%b busy=%b expected 0 0", start_blinking, busy);
        end
        press_code(16'h1234);
        tick(1);
        checks++;
        if (unlocked !== 1'b1) begin
            failures++;
            $display("FAIL code_kept: unlocked=%b expected 1", unlocked);
        end
        // Abort programming with lock_req after a partial entry.
        prog_req = 1'b1;
        tick(1);
        prog_req = 1'b0;
        press(4'd5);
        press(4'd5);
        pulse_lock();
        checks++;
        if (unlocked !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL prog_abort: unlocked=%b busy=%b expected 0 0", unlocked, busy);
        end
        press_code(16'h1234);
        tick(1);
        checks++;
        if (unlocked !== 1'b1) begin
            failures++;
            $display("FAIL abort_code_kept: unlocked=%b expected 1", unlocked);
        end
        pulse_lock();
    endtask

    task automatic test_program();
        bit   ok;
        logic bt;
        press_code(16'h1234);
        tick(1);
        prog_req = 1'b1;
        tick(1);
        prog_req = 1'b0;
        checks++;
        if (unlocked !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL prog_enter: unlocked=%b busy=%b expected 1 0", unlocked, busy);
        end
        press_code(16'h9876);
        tick(1);
        checks++;
        if (unlocked !== 1'b0 || busy !== 1'b1 || blink_type !== 1'b1 || start_blinking !== 1'b0) begin
            failures++;
            $display("FAIL prog_commit: unlocked=%b busy=%b type=%b start=%b expected 0 1 1 0", unlocked, busy, blink_type, start_blinking);
        end
        run_blinker(3, ok, bt);
        checks++;
        if (ok !== 1'b1 || bt !== 1'b1) begin
            failures++;
            $display("FAIL prog_blink: handshake=%b type=%b expected 1 1", ok, bt);
        end
        press_code(16'h1234);
        run_blinker(3, ok, bt);
        checks++;
        if (ok !== 1'b1 || bt !== 1'b0 || unlocked !== 1'b0) begin
            failures++;
            $display("FAIL old_code_rejected: handshake=%b type=%b unlocked=%b expected 1 0 0", ok, bt, unlocked);
        end
        press_code(16'h9876);
        tick(1);
        checks++;
        if (unlocked !== 1'b1) begin
            failures++;
            $display("FAIL new_code: unlocked=%b expected 1", unlocked);
        end
        pulse_lock();
    endtask

    task automatic test_reset_mid_blink();
        press_code(16'h1234);
        tick(2);
        done_blinking = 1'b0;
        tick(2);
        checks++;
        if (start_blinking !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_blink_active: start=%b busy=%b expected 1 1", start_blinking, busy);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (start_blinking !== 1'b0 || busy !== 1'b0 || unlocked !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: start=%b busy=%b unlocked=%b expected 0 0 0", start_blinking, busy, unlocked);
        end
        done_blinking = 1'b1;
        @(posedge hwclk);
        #1;
        tick(1);
        rst_n = 1'b1;
        tick(4);
        press_code(16'h1234);
        tick(1);
        checks++;
        if (unlocked !== 1'b1) begin
            failures++;
            $display("FAIL default_code_restored: unlocked=%b expected 1", unlocked);
        end
        pulse_lock();
    endtask

    task automatic test_busy_keys();
        bit   ok;
        logic bt;
        press_code(16'h5555);
        tick(1);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_set: busy=%b expected 1", busy);
        end
        press(4'd9);
        press(4'd9);
        run_blinker(2, ok, bt);
        checks++;
        if (ok !== 1'b1 || bt !== 1'b0) begin
            failures++;
            $display("FAIL busy_blink: handshake=%b type=%b expected 1 0", ok, bt);
        end
        press_code(16'h1234);
        tick(1);
        checks++;
        if (unlocked !== 1'b1 || start_blinking !== 1'b0) begin
            failures++;
            $display("FAIL busy_keys_dropped: unlocked=%b start=%b expected 1 0", unlocked, start_blinking);
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        key_valid     = 1'b0;
        key_digit     = 4'd0;
        prog_req      = 1'b0;
        lock_req      = 1'b0;
        done_blinking = 1'b1;
        @(posedge hwclk);
        #1;
        test_reset();
        test_unlock();
        test_wrong_code();
        test_timeout();
        test_invalid_and_priority();
        test_program();
        test_reset_mid_blink();
        test_busy_keys();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
